dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the byte-addressed data memory. It shares the memory between requester 0 (CPU load/store path) and requester 1 (debug/DMA loader). It uses round-robin priority and a request/grant/response handshake, and registers read data for one cycle. It drives the memory's MemRead, MemWrite, inst, addr and WriteData inputs and samples its ReadData output.

Parameters:
ADDR_W, 32, address width of requesters and memory.
DATA_W, 32, data width.
MEM_BYTES, 128, memory size in bytes; used only by the optional check.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  synchronous, active-high reset.
req0 / req1  input  1  access request per requester; held with its fields until gnt.
we0 / we1  input  1  1 = store, 0 = load.
f3_0 / f3_1  input  3  access type: 010 word, 000 byte signed, 100 byte unsigned (loads only).
addr0 / addr1  input  ADDR_W  byte address.
wdata0 / wdata1  input  DATA_W  store data.
gnt0 / gnt1  output  1  request accepted this cycle (combinational, IDLE only).
rvalid0 / rvalid1  output  1  one-cycle response strobe, one cycle after gnt.
rdata  output  DATA_W  load result, valid with rvalid; 0 for stores.
err  output  1  response error flag, valid with rvalid; tied 0 unless feature enabled.
mem_read, mem_write  output  1  to memory MemRead/MemWrite.
mem_inst  output  3  to memory inst.
mem_addr  output  ADDR_W  to memory addr.
mem_wdata  output  DATA_W  to memory WriteData.
mem_rdata  input  DATA_W  from memory ReadData.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- FSM states:
  - IDLE: if no req, stay in IDLE. If any req, select a winner, assert its gnt and drive the mem_* ports from its fields in the same cycle. On the edge: latch mem_rdata (loads) or 0 (stores) into rdata, record the winner, go to RESP.
  - RESP: assert rvalid of the recorded winner for exactly one cycle. Force mem_read = mem_write = 0. Flip the priority pointer to the non-winner. Return to IDLE.
- Throughput: at most one access per 2 cycles. Load latency is 1 cycle from gnt to rvalid.
- Arbitration:
  - If only one req is asserted, that requester wins.
  - If both are asserted, the winner is the pointer. The pointer resets to 0.
  - gnt0 and gnt1 are never both 1.
- Memory port values when not granting: all mem_* outputs are 0.
  - mem_read = ~we of the winner; mem_write = we of the winner.
- Reset values: state = IDLE, pointer = 0. gnt*, rvalid*, rdata, err and all mem_* outputs are 0.
- Reset mid-operation: reset in RESP drops rvalid that cycle. The pending response is lost, and the requester must re-request.
- Requests in RESP are ignored (no gnt); they are serviced in the next IDLE cycle.
- A requester deasserting req before gnt is legal and is simply never granted.
- Unsupported f3: passed through unchanged to mem_inst; the memory defines the result.

Optional Feature:
- Macro: DMEM_ARB_CHECK_EN.
- With it defined, the winner's access is checked in IDLE. The access is in error if:
  - f3 = 010 and addr[1:0] != 0, or
  - addr + size > MEM_BYTES (size = 4 for f3 = 010, else 1).
- On error: grant still given, mem_read and mem_write held 0 (memory untouched). In RESP: err = 1, rdata = 0.
- Without it: err is tied 0 and no checking logic is present.

Decomposition:
- Shared package dmem_pkg:
  - f3 constants F3_WORD = 3'b010, F3_BYTE = 3'b000, F3_BYTEU = 3'b100.
  - FSM state encoding ST_IDLE / ST_RESP.
- One natural sub-module: rr_arb2, the 2-input round-robin picker. Inputs: req[1:0] and pointer. Output: one-hot grant.
- FSM, mux and response register remain in dmem_arbiter.

Test Plan:
- Single store then load: req0, we0 = 1, f3 = 010, addr 0x10, wdata 0xDEADBEEF → gnt0 same cycle, rvalid0 next cycle, rdata = 0. Then a load at addr 0x10 → rdata = 0xDEADBEEF exactly 1 cycle after gnt0.
- Byte sign handling: after storing 0x80 at addr 0x20, f3 = 000 load → 0xFFFFFF80; f3 = 100 load → 0x00000080.
- Contention fairness: req0 and req1 held continuously for 8 cycles after reset → grants alternate 0,1,0,1. No cycle has both gnt set. No gnt appears in any RESP cycle.
- Request during RESP: req1 rises in the RESP cycle of a requester-0 access → gnt1 in the following IDLE cycle. mem_* outputs are 0 during RESP.
- Reset in RESP: assert reset on the cycle rvalid0 would fire → rvalid0 = 0, all outputs 0 next cycle. After release, a pending req0 is granted again.
- With DMEM_ARB_CHECK_EN: word load at addr 0x02, and word store at addr 0x7E → err = 1, rdata = 0, mem_read/mem_write never asserted. Without the macro, err stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-type codes and FSM states.
package dmem_pkg;

  // f3 access-type codes seen on the memory inst port
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_BYTEU = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // One-hot grant; pointer only matters when both requesters are active
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the byte-addressed data memory.
// Grants in IDLE, returns a registered response one cycle later in RESP.
// Optional access checking (alignment / bounds) is enabled by DMEM_ARB_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [2:0]        f3_0,
  input  logic [2:0]        f3_1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_inst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_pkg::*;

  // A memory smaller than one word cannot hold any word access
  if (MEM_BYTES < 4) begin : g_mem_too_small
    $error("dmem_arbiter: MEM_BYTES must be at least 4");
  end

  dmem_state_e       state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              winner_q, winner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        arb_gnt;
  logic [1:0]        gnt;
  logic              win;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              acc_err;
  logic              resp_active;

  rr_arb2 u_arb (
    .req ({req1, req0}),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Grant only in IDLE and never while reset is held; mux the winner's fields
  always_comb begin
    gnt       = (state_q == ST_IDLE && !reset) ? arb_gnt : 2'b00;
    win       = gnt[1];
    sel_we    = win ? we1    : we0;
    sel_f3    = win ? f3_1   : f3_0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
  end

`ifdef DMEM_ARB_CHECK_EN
  logic [ADDR_W:0] acc_end;
  logic            err_q;

  // Misaligned word or access running past the end of memory
  always_comb begin
    acc_end = {1'b0, sel_addr} + ((sel_f3 == F3_WORD) ? (ADDR_W+1)'(4) : (ADDR_W+1)'(1));
    acc_err = ((sel_f3 == F3_WORD) && (sel_addr[1:0] != 2'b00)) ||
              (acc_end > (ADDR_W+1)'(MEM_BYTES));
  end

  // Error flag captured alongside the response data
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && |gnt) begin
      err_q <= acc_err;
    end
  end

  assign err = resp_active & err_q;
`else
  assign acc_err = 1'b0;
  assign err     = 1'b0;
`endif

  // Memory port: driven only in the granting cycle, zero otherwise
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_inst  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (|gnt) begin
      mem_read  = ~sel_we & ~acc_err;
      mem_write = sel_we & ~acc_err;
      mem_inst  = sel_f3;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
  end

  // Next-state: capture response on grant, flip pointer to the loser in RESP
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          winner_d = win;
          rdata_d  = (sel_we || acc_err) ? '0 : mem_rdata;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d   = ~winner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      winner_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      rdata_q  <= rdata_d;
    end
  end

  // A reset landing in RESP suppresses that cycle's response
  assign resp_active = (state_q == ST_RESP) && !reset;
  assign gnt0        = gnt[0];
  assign gnt1        = gnt[1];
  assign rvalid0     = resp_active & ~winner_q;
  assign rvalid1     = resp_active & winner_q;
  assign rdata       = resp_active ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus corner-case sequences,
// with a response scoreboard fed at stimulus time and drained on rvalid.
module tb_dmem_arbiter;
  import dmem_pkg::*;

`ifdef DMEM_ARB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [2:0]  f3_0, f3_1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err;
  logic [31:0] rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_inst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .f3_0      (f3_0),
    .f3_1      (f3_1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .err       (err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_inst  (mem_inst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Behavioural 128-byte memory, little-endian, combinational read
  logic [7:0] mem [128] = '{default: 8'h00};
  logic [6:0] a0, a1, a2, a3;
  assign a0 = mem_addr[6:0];
  assign a1 = a0 + 7'd1;
  assign a2 = a0 + 7'd2;
  assign a3 = a0 + 7'd3;

  always_comb begin
    mem_rdata = '0;
    case (mem_inst)
      F3_WORD:  mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      F3_BYTE:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
      F3_BYTEU: mem_rdata = {24'h0, mem[a0]};
      default:  mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_inst == F3_WORD) begin
        mem[a0] <= mem_wdata[7:0];
        mem[a1] <= mem_wdata[15:8];
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end else begin
        mem[a0] <= mem_wdata[7:0];
      end
    end
  end

  typedef struct {
    int          port;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] rd;
    bit          err;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int port, input logic [31:0] rd, input bit e);
    exp_t x;
    x.port = port;
    x.rd   = rd;
    x.err  = e;
    sbq.push_back(x);
  endtask

  task automatic drive(input int port, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      req0 = 1'b1; we0 = we; f3_0 = f3; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; f3_1 = f3; addr1 = addr; wdata1 = wd;
    end
  endtask

  // Entered and left at posedge+1
  task automatic do_reset();
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One access end-to-end; response data is checked by the monitor via the scoreboard
  task automatic access(input vec_t v);
    bit got;
    drive(v.port, v.we, v.f3, v.addr, v.wdata);
    push_exp(v.port, v.rd, v.err);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = (v.port == 0) ? gnt0 : gnt1;
    end
    check("gnt_seen", got, 1'b1);
    if (got) begin
      check("mem_rdwr", {mem_read, mem_write}, v.err ? 2'b00 : {~v.we, v.we});
      check("mem_addr_inst", {mem_addr, mem_inst}, {v.addr, v.f3});
    end else begin
      void'(sbq.pop_back());
    end
    @(posedge clk);
    #1 req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    if (got) check("rvalid_latency", (v.port == 0) ? rvalid0 : rvalid1, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: exclusivity, quiet memory port, and scoreboard drain on rvalid
  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_exclusive", gnt0 & gnt1, 1'b0);
      if (rvalid0 | rvalid1) begin
        check("resp_quiet", {gnt0, gnt1, mem_read, mem_write, mem_addr}, '0);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got rvalid=%b%b expected none", rvalid1, rvalid0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rvalid_port", {rvalid1, rvalid0}, (e.port == 1) ? 2'b10 : 2'b01);
          check("rdata", rdata, e.rd);
          check("err", err, e.err);
        end
      end else if (!(gnt0 | gnt1)) begin
        check("idle_mem_zero", {mem_read, mem_write, mem_inst, mem_addr, mem_wdata}, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{0, 1'b1, F3_WORD,  32'h10, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{0, 1'b0, F3_WORD,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1, 1'b1, F3_BYTE,  32'h20, 32'h0000_0080, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1, 1'b0, F3_BYTE,  32'h20, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{0, 1'b0, F3_BYTEU, 32'h20, 32'h0,        32'h0000_0080, 1'b0};
    vecs[5]  = '{1, 1'b1, F3_WORD,  32'h40, 32'h12345678, 32'h0000_0000, 1'b0};
    vecs[6]  = '{0, 1'b0, F3_WORD,  32'h40, 32'h0,        32'h12345678, 1'b0};
    vecs[7]  = '{1, 1'b0, F3_BYTEU, 32'h41, 32'h0,        32'h0000_0056, 1'b0};
    vecs[8]  = '{0, 1'b0, F3_BYTE,  32'h43, 32'h0,        32'h0000_0012, 1'b0};
    vecs[9]  = '{1, 1'b1, F3_WORD,  32'h7C, 32'hA5A55A5A, 32'h0000_0000, 1'b0};
    vecs[10] = '{0, 1'b0, F3_WORD,  32'h7C, 32'h0,        32'hA5A55A5A, 1'b0};
    vecs[11] = '{0, 1'b0, F3_BYTE,  32'h7F, 32'h0,        32'hFFFF_FFA5, 1'b0};
    // Misaligned word load; bytes 2..5 are still zero, so rdata is 0 either way
    vecs[12] = '{0, 1'b0, F3_WORD,  32'h02, 32'h0,        32'h0000_0000, CHK};
    // Word store crossing the top of memory
    vecs[13] = '{1, 1'b1, F3_WORD,  32'h7E, 32'h11223344, 32'h0000_0000, CHK};
    // Top word untouched when checked, otherwise its upper half was overwritten
    vecs[14] = '{0, 1'b0, F3_WORD,  32'h7C, 32'h0,
                 CHK ? 32'hA5A55A5A : 32'h33445A5A, 1'b0};

    we0 = 1'b0; we1 = 1'b0; f3_0 = '0; f3_1 = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;

    // Outputs are quiet while reset is held, even with requests present
    @(posedge clk);
    #1 req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    check("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, rdata, err,
                            mem_read, mem_write, mem_inst, mem_addr, mem_wdata}, '0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      access(vecs[i]);
    end

    // Contention: both held for 8 cycles from reset, grants alternate 0,1,0,1
    do_reset();
    drive(0, 1'b0, F3_WORD, 32'h10, 32'h0);
    drive(1, 1'b0, F3_WORD, 32'h40, 32'h0);
    push_exp(0, 32'hDEADBEEF, 1'b0);
    push_exp(1, 32'h12345678, 1'b0);
    push_exp(0, 32'hDEADBEEF, 1'b0);
    push_exp(1, 32'h12345678, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("fair_gnt", {gnt1, gnt0}, (c % 2 == 1) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10));
      @(posedge clk);
      #1;
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Request arriving during RESP waits for the next IDLE cycle
    drive(0, 1'b0, F3_WORD, 32'h10, 32'h0);
    push_exp(0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("rr_gnt0", gnt0, 1'b1);
    @(posedge clk);
    #1 req0 = 1'b0;
    drive(1, 1'b0, F3_WORD, 32'h40, 32'h0);
    push_exp(1, 32'h12345678, 1'b0);
    @(negedge clk);
    check("resp_blocks_gnt", {gnt1, mem_read, mem_write, mem_inst, mem_addr, mem_wdata}, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rr_gnt1_next_idle", gnt1, 1'b1);
    @(posedge clk);
    #1 req1 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Reset in RESP: response dropped, held request is granted again after release
    drive(0, 1'b0, F3_WORD, 32'h10, 32'h0);
    @(negedge clk);
    check("pre_reset_gnt0", gnt0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_in_resp", {gnt0, gnt1, rvalid0, rvalid1, rdata, err,
                            mem_read, mem_write, mem_inst, mem_addr, mem_wdata}, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    push_exp(0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("regrant_after_reset", {gnt1, gnt0}, 2'b01);
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    check("regrant_rvalid0", rvalid0, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);

    check("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
